// File: rtl/floor_scroller.sv
// floor_scroller
//   Writer side of the floor-geometry buses read by the floor renderer and the
//   collision logic. It holds the top line, gap left edge and gap width of the
//   three floors. On each accepted frame tick, every floor scrolls up by the
//   captured speed. The floors are updated one per cycle in the order 0, 1, 2.
//   A floor that would pass above the first visible line respawns at the
//   bottom. Its new gap comes from a free-running 16-bit LFSR.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   frame_tick   one-cycle pulse per frame; ignored while busy or disabled
//   enable       game running
//   speed[2:0]   lines scrolled per frame
//   yPos         floor top lines      {floor2, floor1, floor0}, 10 bits each
//   gapsPos      gap left edges       same packing
//   gapsWidth    gap widths           same packing
//   busy         update sequence in progress
//   update_done  one-cycle pulse after floor2 has been updated
//   respawn_mask floors respawned in the update; valid while update_done=1

module floor_scroller #(
  parameter int unsigned V_TOP       = 31,
  parameter int unsigned SPACING     = 160,
  parameter int unsigned FLOOR_THICK = 10,
  parameter int unsigned H_LEFT      = 144,
  parameter int unsigned GAP_MIN     = 48,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [2:0]  speed,
  output logic [29:0] yPos,
  output logic [29:0] gapsPos,
  output logic [29:0] gapsWidth,
  output logic        busy,
  output logic        update_done,
  output logic [2:0]  respawn_mask
);

  localparam logic [9:0] Y_TOP_V    = 10'(V_TOP);
  localparam logic [9:0] WRAP_V     = 10'(3 * SPACING);
  localparam logic [9:0] H_LEFT_V   = 10'(H_LEFT);
  localparam logic [9:0] GAP_MIN_V  = 10'(GAP_MIN);

  localparam logic [2:0][9:0] Y_RST = {
    10'(V_TOP + 3 * SPACING - FLOOR_THICK),
    10'(V_TOP + 2 * SPACING - FLOOR_THICK),
    10'(V_TOP + 1 * SPACING - FLOOR_THICK)
  };
  localparam logic [2:0][9:0] GP_RST = {10'd592, 10'd400, 10'd208};
  localparam logic [2:0][9:0] GW_RST = {GAP_MIN_V, GAP_MIN_V, GAP_MIN_V};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UPD0 = 2'd1,
    UPD1 = 2'd2,
    UPD2 = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [2:0]      spd_q, spd_d;
  logic [2:0][9:0] y_q, y_d;
  logic [2:0][9:0] gp_q, gp_d;
  logic [2:0][9:0] gw_q, gw_d;
  logic [2:0]      acc_q, acc_d;
  logic            done_q, done_d;
  logic [2:0]      mask_q, mask_d;

  logic [2:0]      upd_sel;
  logic [2:0][9:0] dec;
  logic [2:0]      above_top;
  logic [9:0]      new_gw;
  logic [9:0]      new_gp;

  // Fibonacci LFSR, taps 16,14,13,11. It advances on every clock so that the
  // gap sequence depends on the timing of play, not only on the frame count.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // A candidate position and respawn condition are computed for every floor.
  // Only the floor selected by the current UPD state is committed.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      dec[i]       = y_q[i] - {7'b0, spd_q};
      above_top[i] = (dec[i] < Y_TOP_V);
    end
    new_gw = GAP_MIN_V + {4'b0, lfsr_q[3:0], 2'b00};
    new_gp = H_LEFT_V + {1'b0, lfsr_q[12:4]};
  end

  always_comb begin
    state_d = state_q;
    spd_d   = spd_q;
    y_d     = y_q;
    gp_d    = gp_q;
    gw_d    = gw_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    mask_d  = '0;
    upd_sel = '0;

    unique case (state_q)
      IDLE: begin
        if (frame_tick && enable) begin
          state_d = UPD0;
          spd_d   = speed;
          acc_d   = '0;
        end
      end
      UPD0: begin
        upd_sel = 3'b001;
        state_d = UPD1;
      end
      UPD1: begin
        upd_sel = 3'b010;
        state_d = UPD2;
      end
      UPD2: begin
        upd_sel = 3'b100;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < 3; i++) begin
      if (upd_sel[i]) begin
        if (above_top[i]) begin
          // Adding the full loop height keeps the 160-line spacing exact.
          y_d[i]   = dec[i] + WRAP_V;
          gw_d[i]  = new_gw;
          gp_d[i]  = new_gp;
          acc_d[i] = 1'b1;
        end else begin
          y_d[i] = dec[i];
        end
      end
    end

    // The floor2 respawn is folded in here because it is decided in the same
    // cycle that the mask is published.
    if (state_q == UPD2) begin
      done_d = 1'b1;
      mask_d = acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      spd_q   <= '0;
      y_q     <= Y_RST;
      gp_q    <= GP_RST;
      gw_q    <= GW_RST;
      acc_q   <= '0;
      done_q  <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      spd_q   <= spd_d;
      y_q     <= y_d;
      gp_q    <= gp_d;
      gw_q    <= gw_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
    end
  end

  assign yPos         = y_q;
  assign gapsPos      = gp_q;
  assign gapsWidth    = gw_q;
  assign busy         = (state_q != IDLE);
  assign update_done  = done_q;
  assign respawn_mask = mask_q;

endmodule

// File: tb/tb_floor_scroller.sv
// tb_floor_scroller
//   Directed bench for floor_scroller. Expected positions are hand-computed.
//   Respawned gaps are predicted from a reference LFSR that runs alongside
//   the DUT, sampled during the UPD0 cycle.

module tb_floor_scroller;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        enable;
  logic [2:0]  speed;
  logic [29:0] yPos;
  logic [29:0] gapsPos;
  logic [29:0] gapsWidth;
  logic        busy;
  logic        update_done;
  logic [2:0]  respawn_mask;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_lfsr;

  floor_scroller #(
    .V_TOP      (31),
    .SPACING    (160),
    .FLOOR_THICK(10),
    .H_LEFT     (144),
    .GAP_MIN    (48),
    .SEED       (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .enable      (enable),
    .speed       (speed),
    .yPos        (yPos),
    .gapsPos     (gapsPos),
    .gapsWidth   (gapsWidth),
    .busy        (busy),
    .update_done (update_done),
    .respawn_mask(respawn_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11, advancing on every edge out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Issue one tick, optionally held for a second cycle while the DUT is
  // already busy. Then watch a bounded window for the completion pulse.
  task automatic do_tick(input bit hold2, output int done_cnt, output logic [2:0] mask_or,
                         output logic busy_seen, output logic [15:0] lfsr_upd0);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    lfsr_upd0 = m_lfsr;
    busy_seen = busy;
    if (hold2) @(negedge clk);
    frame_tick = 1'b0;
    done_cnt = 0;
    mask_or  = '0;
    repeat (10) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (update_done === 1'b1) begin
        done_cnt++;
        mask_or |= respawn_mask;
      end
    end
  endtask

  int          dc;
  int          total_done;
  logic [2:0]  mk;
  logic [2:0]  mask_all;
  logic        bs;
  logic [15:0] lv;
  logic [29:0] y_save, gp_save, gw_save;
  int          exp_gw, exp_gp;

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    enable     = 1'b0;
    speed      = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in the middle of an update sequence.
    enable = 1'b1;
    speed  = 3'd3;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    check("mid_upd_floor0_moved", {22'd0, yPos[9:0]}, 32'd178);
    #1 rst_n = 1'b0;
    #1;
    check("rst_yPos",      {2'b0, yPos},      {2'b0, 10'd501, 10'd341, 10'd181});
    check("rst_gapsPos",   {2'b0, gapsPos},   {2'b0, 10'd592, 10'd400, 10'd208});
    check("rst_gapsWidth", {2'b0, gapsWidth}, {2'b0, 10'd48, 10'd48, 10'd48});
    check("rst_busy",      {31'd0, busy},        32'd0);
    check("rst_done",      {31'd0, update_done}, 32'd0);
    check("rst_mask",      {29'd0, respawn_mask}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Scroll at speed 7 for 21 frames with no respawn.
    speed = 3'd7;
    total_done = 0;
    mask_all   = '0;
    for (int i = 0; i < 21; i++) begin
      do_tick(1'b0, dc, mk, bs, lv);
      total_done += dc;
      mask_all   |= mk;
    end
    check("scroll_yPos",  {2'b0, yPos}, {2'b0, 10'd354, 10'd194, 10'd34});
    check("scroll_done",  total_done, 32'd21);
    check("scroll_mask",  {29'd0, mask_all}, 32'd0);

    // Frame 22: floor0 falls from 34 to 27, which is above line 31, so it respawns.
    do_tick(1'b0, dc, mk, bs, lv);
    exp_gw = 48 + 4 * int'(lv[3:0]);
    exp_gp = 144 + int'(lv[12:4]);
    check("respawn_yPos",   {2'b0, yPos}, {2'b0, 10'd347, 10'd187, 10'd507});
    check("respawn_done",   dc, 32'd1);
    check("respawn_mask",   {29'd0, mk}, 32'd1);
    check("respawn_gw0",    {22'd0, gapsWidth[9:0]}, exp_gw);
    check("respawn_gp0",    {22'd0, gapsPos[9:0]},   exp_gp);
    check("respawn_gw_oth", {12'd0, gapsWidth[29:10]}, {12'd0, 10'd48, 10'd48});
    check("respawn_gp_oth", {12'd0, gapsPos[29:10]},   {12'd0, 10'd592, 10'd400});

    // A second tick while busy is dropped.
    do_tick(1'b1, dc, mk, bs, lv);
    check("busytick_done", dc, 32'd1);
    check("busytick_yPos", {2'b0, yPos}, {2'b0, 10'd340, 10'd180, 10'd500});

    // Ticks are ignored while disabled.
    y_save  = yPos;
    gp_save = gapsPos;
    gw_save = gapsWidth;
    enable  = 1'b0;
    do_tick(1'b0, dc, mk, bs, lv);
    check("dis_busy", {31'd0, bs}, 32'd0);
    check("dis_done", dc, 32'd0);
    check("dis_buses", {2'b0, yPos ^ y_save} | {2'b0, gapsPos ^ gp_save} | {2'b0, gapsWidth ^ gw_save}, 32'd0);

    // Speed 0 still runs the sequence without moving anything.
    enable = 1'b1;
    speed  = 3'd0;
    do_tick(1'b0, dc, mk, bs, lv);
    check("spd0_busy", {31'd0, bs}, 32'd1);
    check("spd0_done", dc, 32'd1);
    check("spd0_mask", {29'd0, mk}, 32'd0);
    check("spd0_yPos", {2'b0, yPos}, {2'b0, y_save});

    // Boundary at speed 1: floor0 lands exactly on line 31, then respawns at 510.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    speed = 3'd1;
    total_done = 0;
    mask_all   = '0;
    for (int i = 0; i < 150; i++) begin
      do_tick(1'b0, dc, mk, bs, lv);
      total_done += dc;
      mask_all   |= mk;
    end
    check("bnd_y0_at_top", {22'd0, yPos[9:0]}, 32'd31);
    check("bnd_done",      total_done, 32'd150);
    check("bnd_mask",      {29'd0, mask_all}, 32'd0);
    do_tick(1'b0, dc, mk, bs, lv);
    check("bnd_yPos_wrap", {2'b0, yPos}, {2'b0, 10'd350, 10'd190, 10'd510});
    check("bnd_mask_wrap", {29'd0, mk}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/floor_scroller.md
Name: floor_scroller

Overview:
- Writer side of the floor-geometry buses that the floor renderer reads.
- Owns the vertical position, gap position and gap width of the three floors.
- Once per video frame, scrolls every floor upward by a programmable speed.
- When a floor leaves the top of the visible area, it respawns at the bottom with a pseudo-random gap from an internal LFSR.
- Sits between the game controller (frame tick, enable, speed) and the renderer/collision logic, which consume the packed buses.

Parameters:
- V_TOP, 31, first visible vc line.
- SPACING, 160, vertical distance between consecutive floors (3*SPACING = visible height 480).
- FLOOR_THICK, 10, floor thickness in lines (matches the renderer constant).
- H_LEFT, 144, first visible hc pixel.
- GAP_MIN, 48, minimum gap width in pixels.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  single-cycle pulse, once per frame (vsync)
- enable  in  1  game running; ticks are ignored while low
- speed  in  3  pixels scrolled per frame, 0..7
- yPos  out  30  three 10-bit floor top lines; floor0=[9:0], floor1=[19:10], floor2=[29:20]
- gapsPos  out  30  three 10-bit gap left edges, same packing
- gapsWidth  out  30  three 10-bit gap widths, same packing
- busy  out  1  update sequence in progress
- update_done  out  1  one-cycle pulse when a frame update completes
- respawn_mask  out  3  floors respawned in the last update; valid while update_done=1

Behaviour:
- One clock; reset is asynchronous and active-low. All state is cleared immediately on rst_n=0, including mid-update.
- Reset values:
  - y_i = V_TOP + (i+1)*SPACING - FLOOR_THICK, giving 181, 341, 501.
  - gapsPos = 208, 400, 592.
  - gapsWidth = GAP_MIN for all three floors.
  - busy=0, update_done=0, respawn_mask=0.
  - LFSR=SEED; state=IDLE.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every clk edge regardless of state.
- FSM states: IDLE, UPD0, UPD1, UPD2.
  - IDLE -> UPD0 on the edge where frame_tick=1 and enable=1. speed is captured into spd_r on that same edge.
  - UPD0 -> UPD1 -> UPD2 -> IDLE unconditionally, one cycle each.
  - busy=1 whenever state != IDLE.
  - frame_tick arriving while busy is dropped, not queued.
- Per-floor update, on the edge leaving UPDi, floor i only:
  - d = y_i - spd_r, computed in 10 bits.
  - If d >= V_TOP: y_i <= d; gap registers unchanged.
  - Otherwise (respawn):
    - y_i <= d + 3*SPACING, which preserves spacing; maximum result is 510.
    - gapsWidth_i <= GAP_MIN + 4*lfsr[3:0], range 48..108.
    - gapsPos_i <= H_LEFT + lfsr[12:4], range 144..655.
    - Set mask bit i.
  - The gap right edge never exceeds 763, so it always stays on screen.
  - Each floor uses the LFSR value present in its own UPD cycle.
- Completion:
  - On the edge UPD2 -> IDLE, update_done <= 1 and respawn_mask <= accumulated mask.
  - On the next edge, update_done <= 0 and respawn_mask <= 0.
  - The accumulator clears on entry to UPD0.
- Latency: with tick sampled at edge E0, floor0 outputs change at E1, floor1 at E2, floor2 at E3. update_done is high for the cycle following E3.
- Outputs change only on UPD edges and are otherwise stable for the renderer.
- speed=0: the sequence still runs and update_done pulses, but there is no movement and the mask is 000.
- enable low mid-sequence: the running sequence completes; subsequent ticks are ignored.
- Floors never cross one another. The packing order is fixed per floor, not sorted by height.

Test Plan:
- Reset check: assert rst_n=0 mid-UPD1, then release. Required: yPos={501,341,181}, gapsPos={592,400,208}, gapsWidth={48,48,48}, busy=0, state IDLE.
- Scroll, speed=7, enable=1, 21 ticks: floor0=34, floor1=194, floor2=354; update_done seen 21 times; mask always 000.
- Respawn: one further tick after the above. Floor0 -> 507 (27+480); mask=001 during update_done. Floor0 gapsWidth/gapsPos must match the bench LFSR model sampled at the UPD0 cycle, in range 48..108 / 144..655.
- Boundary, speed=1: floor0 reaches exactly 31 after 150 ticks with no respawn. Tick 151 gives 510 with mask bit0 set.
- Tick while busy: issue a second frame_tick one cycle after the first. Required: exactly one update, with floor0 decremented once.
- enable=0 or speed=0: ticks with enable=0 produce busy=0 and unchanged buses. speed=0 with enable=1 produces update_done pulses, mask 000, and unchanged yPos.
